// File: rtl/mux_types_pkg.sv
// Shared types for the memory arbiter slice.
// RAM handshake states, arbiter FSM states, defaults.
package mux_types_pkg;

  typedef enum logic [1:0] {
    FREE,
    BUSY,
    ACCESS,
    ERROR
  } ramstate_t;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_IGNT,
    ARB_DGNT
  } arb_state_t;

  localparam int STARVE_MAX_DEF = 4;

  function automatic logic ram_done(ramstate_t s);
    return (s == ACCESS) || (s == ERROR);
  endfunction

endpackage

// File: rtl/memory_arbiter_if.sv
// Requester and RAM side signals of the memory arbiter.
// slave = arbiter view, master = caches/RAM view.
interface memory_arbiter_if;
  import mux_types_pkg::*;

  logic        iREN;
  logic [31:0] iaddr;
  logic        iwait;
  logic [31:0] iload;
  logic        dREN;
  logic        dWEN;
  logic [31:0] daddr;
  logic [31:0] dstore;
  logic        dwait;
  logic [31:0] dload;
  logic        ramREN;
  logic        ramWEN;
  logic [31:0] ramaddr;
  logic [31:0] ramstore;
  logic [31:0] ramload;
  ramstate_t   ramstate;
  logic        ramerr;

  modport slave (
    input  iREN, iaddr,
    input  dREN, dWEN, daddr, dstore,
    input  ramload, ramstate,
    output iwait, iload,
    output dwait, dload,
    output ramREN, ramWEN, ramaddr, ramstore,
    output ramerr
  );

  modport master (
    output iREN, iaddr,
    output dREN, dWEN, daddr, dstore,
    output ramload, ramstate,
    input  iwait, iload,
    input  dwait, dload,
    input  ramREN, ramWEN, ramaddr, ramstore,
    input  ramerr
  );

endinterface

// File: rtl/arb_starve_ctr.sv
// Saturating count of data grants taken while a fetch waits.
// starved forces the next IDLE decision toward the fetch side.
module arb_starve_ctr #(
  parameter int MAX = 4,
  localparam int CW = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic nrst,
  input  logic inc,
  input  logic clr,
  output logic starved
);

  logic [CW-1:0] count;

  always_ff @(posedge clk) begin
    if (!nrst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && !starved) begin
      count <= count + CW'(1);
    end
  end

  assign starved = (count == CW'(MAX));

endmodule

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter: data side first, fetch guaranteed
// progress via starvation counter; one transaction in flight.
module memory_arbiter
  import mux_types_pkg::*;
#(
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input logic            CLK,
  input logic            nRST,
  memory_arbiter_if.slave bus
);

  arb_state_t state, nxt;

  logic ireq, dreq, done;
  logic in_i, in_d;
  logic icmp, dcmp;
  logic starved, inc, clr;

  assign ireq = bus.iREN;
  assign dreq = bus.dREN | bus.dWEN;
  assign done = ram_done(bus.ramstate);
  assign in_i = (state == ARB_IGNT);
  assign in_d = (state == ARB_DGNT);

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state <= ARB_IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Owner is fixed until completion or until it withdraws.
  always_comb begin
    nxt = state;
    unique case (state)
      ARB_IDLE: begin
        if (dreq && !starved) begin
          nxt = ARB_DGNT;
        end else if (ireq) begin
          nxt = ARB_IGNT;
        end
      end
      ARB_IGNT: begin
        if (!ireq || done) begin
          nxt = ARB_IDLE;
        end
      end
      ARB_DGNT: begin
        if (!dreq || done) begin
          nxt = ARB_IDLE;
        end
      end
      default: nxt = ARB_IDLE;
    endcase
  end

  assign inc = (state == ARB_IDLE)
             && (nxt == ARB_DGNT) && ireq;
  assign clr = (state == ARB_IDLE)
             && ((nxt == ARB_IGNT) || !ireq);

  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_ctr (
    .clk     (CLK),
    .nrst    (nRST),
    .inc     (inc),
    .clr     (clr),
    .starved (starved)
  );

  // Enables follow the owner's request so a withdrawal is seen at once.
  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    unique case (1'b1)
      in_i: begin
        bus.ramREN  = ireq;
        bus.ramaddr = bus.iaddr;
      end
      in_d: begin
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramWEN   = bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
      end
      default: ;
    endcase
  end

  assign icmp = in_i && ireq && done;
  assign dcmp = in_d && dreq && done;

  assign bus.iwait  = ~icmp;
  assign bus.dwait  = ~dcmp;
  assign bus.iload  = bus.ramload;
  assign bus.dload  = bus.ramload;
  assign bus.ramerr = (icmp | dcmp)
                    && (bus.ramstate == ERROR);

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios
// plus randomized traffic against a memory/fairness model.
module tb_memory_arbiter;
  import mux_types_pkg::*;

  logic CLK = 1'b0;
  logic nRST = 1'b0;
  int checks = 0;
  int errors = 0;
  logic [31:0] mem [16];

  memory_arbiter_if bus();

  memory_arbiter #(.STARVE_MAX(4)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic samp();
    @(negedge CLK);
  endtask

  task automatic quiet();
    bus.iREN = 1'b0; bus.dREN = 1'b0; bus.dWEN = 1'b0;
    bus.iaddr = '0; bus.daddr = '0; bus.dstore = '0;
    bus.ramstate = FREE; bus.ramload = '0;
  endtask

  task automatic test_reset();
    nRST = 1'b0;
    bus.iREN = 1'b1; bus.dREN = 1'b1;
    bus.iaddr = 32'h4; bus.daddr = 32'h8;
    repeat (3) step();
    samp();
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0) begin
      errors++;
      $display("FAIL rst_enables got %b%b exp 00", bus.ramREN, bus.ramWEN);
    end
    checks++;
    if (bus.iwait !== 1'b1 || bus.dwait !== 1'b1) begin
      errors++;
      $display("FAIL rst_waits got %b%b exp 11", bus.iwait, bus.dwait);
    end
    checks++;
    if (bus.ramerr !== 1'b0) begin
      errors++;
      $display("FAIL rst_ramerr got %b exp 0", bus.ramerr);
    end
    step();
    nRST = 1'b1;
    samp();
    checks++;
    if (bus.ramREN !== 1'b0) begin
      errors++;
      $display("FAIL rst_release_idle ramREN got %b exp 0", bus.ramREN);
    end
    step();
    samp();
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h8) begin
      errors++;
      $display("FAIL rst_first_grant got %b/%h exp 1/00000008", bus.ramREN, bus.ramaddr);
    end
    quiet();
    step(); step();
  endtask

  task automatic test_fetch();
    int lows = 0;
    step();
    bus.iREN = 1'b1; bus.iaddr = 32'h40;
    samp();
    checks++;
    if (bus.ramREN !== 1'b0) begin
      errors++;
      $display("FAIL fetch_idle ramREN got %b exp 0", bus.ramREN);
    end
    for (int c = 0; c < 3; c++) begin
      step();
      bus.ramstate = (c < 2) ? BUSY : ACCESS;
      bus.ramload = (c < 2) ? $urandom : 32'h8C220004;
      samp();
      checks++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40) begin
        errors++;
        $display("FAIL fetch_addr c%0d got %b/%h exp 1/00000040", c, bus.ramREN, bus.ramaddr);
      end
      if (bus.iwait === 1'b0) lows++;
      if (c == 2) begin
        checks++;
        if (bus.iwait !== 1'b0 || bus.iload !== 32'h8C220004) begin
          errors++;
          $display("FAIL fetch_data got %b/%h exp 0/8c220004", bus.iwait, bus.iload);
        end
      end
    end
    step();
    bus.iREN = 1'b0; bus.ramstate = FREE;
    samp();
    if (bus.iwait === 1'b0) lows++;
    checks++;
    if (lows != 1) begin
      errors++;
      $display("FAIL fetch_pulse iwait low cycles got %0d exp 1", lows);
    end
  endtask

  task automatic test_write_priority();
    step();
    bus.iREN = 1'b1; bus.iaddr = 32'h10;
    bus.dWEN = 1'b1; bus.dREN = 1'b1;
    bus.daddr = 32'h200; bus.dstore = 32'hDEADBEEF;
    samp();
    step();
    bus.ramstate = ACCESS;
    samp();
    checks++;
    if ({bus.ramWEN, bus.ramREN} !== 2'b10 || bus.ramaddr !== 32'h200
        || bus.ramstore !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL wr_grant got %b%b/%h/%h exp 10/00000200/deadbeef",
               bus.ramWEN, bus.ramREN, bus.ramaddr, bus.ramstore);
    end
    checks++;
    if (bus.dwait !== 1'b0 || bus.iwait !== 1'b1) begin
      errors++;
      $display("FAIL wr_done waits got d%b i%b exp d0 i1", bus.dwait, bus.iwait);
    end
    step();
    bus.dWEN = 1'b0; bus.dREN = 1'b0; bus.ramstate = FREE;
    samp();
    checks++;
    if (bus.ramREN !== 1'b0 || bus.ramWEN !== 1'b0 || bus.iwait !== 1'b1) begin
      errors++;
      $display("FAIL wr_gap got %b%b%b exp 001", bus.ramREN, bus.ramWEN, bus.iwait);
    end
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h12345678;
    samp();
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h10
        || bus.iwait !== 1'b0 || bus.iload !== 32'h12345678) begin
      errors++;
      $display("FAIL wr_then_fetch got %b/%h/%b/%h exp 1/00000010/0/12345678",
               bus.ramREN, bus.ramaddr, bus.iwait, bus.iload);
    end
    step();
    quiet();
    step();
  endtask

  task automatic test_starvation();
    int dg = 0;
    bit ig = 1'b0;
    step();
    bus.iREN = 1'b1; bus.iaddr = 32'h80;
    bus.dREN = 1'b1; bus.daddr = 32'h300;
    for (int c = 0; c < 30 && !ig; c++) begin
      if (c > 0) step();
      #1;
      bus.ramstate = (bus.ramREN | bus.ramWEN) ? ACCESS : FREE;
      samp();
      if (bus.ramREN === 1'b1 && bus.ramaddr === 32'h300) dg++;
      else if (bus.ramREN === 1'b1 && bus.ramaddr === 32'h80) begin
        ig = 1'b1;
        checks++;
        if (dut.u_ctr.count !== 3'd0 || bus.iwait !== 1'b0) begin
          errors++;
          $display("FAIL starve_ignt count/iwait got %0d/%b exp 0/0",
                   dut.u_ctr.count, bus.iwait);
        end
      end
    end
    checks++;
    if (!ig) begin
      errors++;
      $display("FAIL starve_timeout fetch granted got 0 exp 1");
    end
    checks++;
    if (dg != 4) begin
      errors++;
      $display("FAIL starve_dgrants got %0d exp 4", dg);
    end
    quiet();
    step(); step();
  endtask

  task automatic test_error();
    step();
    bus.dREN = 1'b1; bus.daddr = 32'h44;
    samp();
    step();
    bus.ramstate = ERROR;
    samp();
    checks++;
    if (bus.dwait !== 1'b0 || bus.ramerr !== 1'b1 || bus.iwait !== 1'b1) begin
      errors++;
      $display("FAIL err_pulse got d%b e%b i%b exp d0 e1 i1",
               bus.dwait, bus.ramerr, bus.iwait);
    end
    step();
    bus.ramstate = FREE;
    samp();
    checks++;
    if (bus.dwait !== 1'b1 || bus.ramerr !== 1'b0 || bus.ramREN !== 1'b0
        || bus.iwait !== 1'b1) begin
      errors++;
      $display("FAIL err_idle got d%b e%b r%b i%b exp d1 e0 r0 i1",
               bus.dwait, bus.ramerr, bus.ramREN, bus.iwait);
    end
    quiet();
    step();
  endtask

  task automatic test_drop();
    step();
    bus.dREN = 1'b1; bus.daddr = 32'h88;
    bus.iREN = 1'b1; bus.iaddr = 32'h24;
    samp();
    step();
    bus.ramstate = BUSY;
    samp();
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h88) begin
      errors++;
      $display("FAIL drop_grant got %b/%h exp 1/00000088", bus.ramREN, bus.ramaddr);
    end
    step();
    bus.dREN = 1'b0;
    samp();
    checks++;
    if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin
      errors++;
      $display("FAIL drop_same_cycle got r%b d%b exp r0 d1", bus.ramREN, bus.dwait);
    end
    step();
    bus.ramstate = FREE;
    samp();
    checks++;
    if (bus.ramREN !== 1'b0 || bus.dwait !== 1'b1) begin
      errors++;
      $display("FAIL drop_idle got r%b d%b exp r0 d1", bus.ramREN, bus.dwait);
    end
    step();
    bus.ramstate = ACCESS; bus.ramload = 32'h0000A5A5;
    samp();
    checks++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h24 || bus.iwait !== 1'b0) begin
      errors++;
      $display("FAIL drop_then_fetch got %b/%h/%b exp 1/00000024/0",
               bus.ramREN, bus.ramaddr, bus.iwait);
    end
    quiet();
    step();
  endtask

  task automatic test_random();
    bit ip = 0, dp = 0, dw = 0, iok, dok, fin;
    logic [31:0] ia = '0, da = '0, dd = '0;
    int busy = -1, streak = 0, iage = 0, dage = 0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int c = 0; c < 800; c++) begin
      step();
      if (!ip && $urandom_range(0, 2) == 0) begin
        ip = 1; ia = 32'($urandom_range(0, 15)) << 2; iage = 0; streak = 0;
      end
      if (!dp && $urandom_range(0, 1) == 0) begin
        dp = 1; dw = 1'($urandom_range(0, 1));
        da = 32'($urandom_range(0, 15)) << 2; dd = $urandom; dage = 0;
      end
      bus.iREN = ip; bus.iaddr = ia; bus.daddr = da; bus.dstore = dd;
      bus.dWEN = dp && dw;
      bus.dREN = dp && (!dw || ($urandom_range(0, 1) == 1));
      #1;
      if (bus.ramREN | bus.ramWEN) begin
        if (busy < 0) busy = $urandom_range(0, 2);
        if (busy > 0) begin
          busy--; bus.ramstate = BUSY; bus.ramload = $urandom;
        end else begin
          busy = -1;
          bus.ramstate = ($urandom_range(0, 9) == 0) ? ERROR : ACCESS;
          bus.ramload = bus.ramWEN ? $urandom : mem[bus.ramaddr[5:2]];
        end
      end else begin
        busy = -1; bus.ramstate = FREE; bus.ramload = $urandom;
      end
      samp();
      iok = (bus.iwait === 1'b0);
      dok = (bus.dwait === 1'b0);
      fin = (bus.ramREN | bus.ramWEN)
            && (bus.ramstate == ACCESS || bus.ramstate == ERROR);
      checks++;
      if (iok && dok) begin
        errors++;
        $display("FAIL rnd_both_waits c%0d both low", c);
      end
      checks++;
      if ((iok || dok) != fin || (bus.ramREN && bus.ramWEN)) begin
        errors++;
        $display("FAIL rnd_completion c%0d got %b exp %b", c, iok || dok, fin);
      end
      checks++;
      if (bus.ramerr !== ((iok || dok) && bus.ramstate == ERROR)) begin
        errors++;
        $display("FAIL rnd_ramerr c%0d got %b", c, bus.ramerr);
      end
      if (iok) begin
        checks++;
        if (bus.ramaddr !== ia || bus.ramREN !== 1'b1
            || (bus.ramstate == ACCESS && bus.iload !== mem[ia[5:2]])) begin
          errors++;
          $display("FAIL rnd_fetch c%0d addr %h load %h exp %h/%h",
                   c, bus.ramaddr, bus.iload, ia, mem[ia[5:2]]);
        end
        ip = 0; streak = 0;
      end
      if (dok) begin
        checks++;
        if (bus.ramaddr !== da
            || (dw && (bus.ramWEN !== 1'b1 || bus.ramstore !== dd))
            || (!dw && (bus.ramREN !== 1'b1
                || (bus.ramstate == ACCESS && bus.dload !== mem[da[5:2]])))) begin
          errors++;
          $display("FAIL rnd_data c%0d addr %h exp %h w%b", c, bus.ramaddr, da, dw);
        end
        if (dw && bus.ramstate == ACCESS) mem[da[5:2]] = dd;
        dp = 0;
        if (ip) begin
          streak++;
          checks++;
          if (streak > 5) begin
            errors++;
            $display("FAIL rnd_starve c%0d data completions %0d exp <=5", c, streak);
          end
        end
      end
      if (ip) iage++;
      if (dp) dage++;
      checks++;
      if (iage > 60 || dage > 60) begin
        errors++;
        $display("FAIL rnd_progress c%0d ages %0d/%0d exp <=60", c, iage, dage);
        break;
      end
    end
    quiet();
    step(); step();
  endtask

  initial begin
    quiet();
    test_reset();
    test_fetch();
    test_write_priority();
    test_starvation();
    test_error();
    test_drop();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
